// File: rtl/pwm_pkg.sv
// Shared types and the saturating dither step for pwm_dither.
package pwm_pkg;

  typedef enum logic {EMPTY = 1'b0, RUN = 1'b1} pwm_dither_st_t;

  localparam int PWM_W = 32;

  typedef struct packed {
    logic [PWM_W-1:0] dat;
    logic [PWM_W-1:0] acc;
  } pwm_step_t;

  // Operands are zero-extended to PWM_W; dwf selects the fraction width.
  function automatic pwm_step_t pwm_step(input logic [PWM_W-1:0] acc,
                                         input logic [PWM_W-1:0] xi,
                                         input logic [PWM_W-1:0] xf,
                                         input logic [PWM_W-1:0] rng,
                                         input int               dwf);
    logic [PWM_W-1:0] sum;
    logic [PWM_W-1:0] msk;
    logic [PWM_W-1:0] v;
    pwm_step_t        r;
    msk   = (PWM_W'(1) << dwf) - PWM_W'(1);
    sum   = acc + xf;
    v     = xi + ((sum >> dwf) & PWM_W'(1));
    r.acc = sum & msk;
    r.dat = (v > rng) ? rng : v;
    return r;
  endfunction

endpackage

// File: rtl/pwm_dither_ch.sv
// One dither channel: sample hold, error accumulator and saturated output.
module pwm_dither_ch
  import pwm_pkg::*;
#(
  parameter int DWC = 8,
  parameter int DWF = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               ld,
  input  logic               stp,
  input  logic               zro,
  input  logic [DWC+DWF-1:0] s_dat,
  input  logic [DWC-1:0]     rng,
  output logic [DWC-1:0]     m_dat
);

  logic [DWC+DWF-1:0] hld;
  logic [DWC+DWF-1:0] src;
  logic [DWF-1:0]     acc;
  pwm_step_t          r;
  logic               unused_bits;

  assign src = ld ? s_dat : hld;
  assign r   = pwm_step(PWM_W'(acc), PWM_W'(src[DWC+DWF-1:DWF]),
                        PWM_W'(src[DWF-1:0]), PWM_W'(rng), DWF);

  // Upper bits are always zero: results never exceed the operand widths.
  assign unused_bits = ^{r.dat[PWM_W-1:DWC], r.acc[PWM_W-1:DWF]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hld   <= '0;
      acc   <= '0;
      m_dat <= '0;
    end else if (clr) begin
      hld   <= '0;
      acc   <= '0;
      m_dat <= '0;
    end else begin
      if (ld) hld <= s_dat;
      if (ld || stp) begin
        acc   <= r.acc[DWF-1:0];
        m_dat <= r.dat[DWC-1:0];
      end else if (zro) begin
        m_dat <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_dither.sv
// Sample repeater with first-order error-feedback dither feeding the PWM.
// Define PWM_DITHER_HOLD_EN to keep dithering the last sample after underflow.
//
// state | meaning
// EMPTY | no sample held, waiting for s_vld (m_vld=0)
// RUN   | sample held, m_dat valid, repeating for rpt+1 periods
module pwm_dither
  import pwm_pkg::*;
#(
  parameter int DWC = 8,
  parameter int DWF = 8,
  parameter int CHN = 1,
  parameter int DWR = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         ena,
  input  logic [DWR-1:0]               rpt,
  input  logic [DWC-1:0]               rng,
  input  logic [CHN-1:0][DWC+DWF-1:0]  s_dat,
  input  logic                         s_vld,
  output logic                         s_rdy,
  output logic [CHN-1:0][DWC-1:0]      m_dat,
  output logic                         m_vld,
  input  logic                         m_rdy,
  output logic                         unf
);

`ifdef PWM_DITHER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  pwm_dither_st_t st, st_nx;
  logic [DWR-1:0] cnt, cnt_nx;
  logic           ld, stp, zro, unf_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st  <= EMPTY;
      cnt <= '0;
      unf <= 1'b0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      unf <= unf_nx;
    end
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    s_rdy  = 1'b0;
    ld     = 1'b0;
    stp    = 1'b0;
    zro    = 1'b0;
    unf_nx = 1'b0;
    case (st)
      EMPTY: begin
        s_rdy = 1'b1;
        if (s_vld) begin
          ld     = 1'b1;
          cnt_nx = '0;
          st_nx  = RUN;
        end else if (HOLD && m_rdy) begin
          stp = 1'b1;
        end
      end
      RUN: begin
        // rpt is compared live, so a shrink below cnt ends the sample.
        if (m_rdy) begin
          if (cnt < rpt) begin
            stp    = 1'b1;
            cnt_nx = cnt + DWR'(1);
          end else if (s_vld) begin
            s_rdy  = 1'b1;
            ld     = 1'b1;
            cnt_nx = '0;
          end else begin
            st_nx  = EMPTY;
            cnt_nx = '0;
            unf_nx = 1'b1;
            stp    = HOLD;
            zro    = !HOLD;
          end
        end
      end
      default: st_nx = EMPTY;
    endcase
    if (!ena) begin
      st_nx  = EMPTY;
      cnt_nx = '0;
      s_rdy  = 1'b0;
      ld     = 1'b0;
      stp    = 1'b0;
      zro    = 1'b0;
      unf_nx = 1'b0;
    end
  end

  assign m_vld = (st == RUN);

  for (genvar i = 0; i < CHN; i++) begin : g_ch
    pwm_dither_ch #(
      .DWC (DWC),
      .DWF (DWF)
    ) u_ch (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (!ena),
      .ld    (ld),
      .stp   (stp),
      .zro   (zro),
      .s_dat (s_dat[i]),
      .rng   (rng),
      .m_dat (m_dat[i])
    );
  end

endmodule

// File: tb/tb_pwm_dither.sv
// Self-checking bench for pwm_dither (two channels), directed plus random traffic.
module tb_pwm_dither;

  localparam int DWC = 8;
  localparam int DWF = 8;
  localparam int CHN = 2;
  localparam int DWR = 8;

`ifdef PWM_DITHER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                        clk   = 1'b0;
  logic                        rstn  = 1'b1;
  logic                        ena   = 1'b0;
  logic [DWR-1:0]              rpt   = '0;
  logic [DWC-1:0]              rng   = '0;
  logic [CHN-1:0][DWC+DWF-1:0] s_dat = '0;
  logic                        s_vld = 1'b0;
  logic                        s_rdy;
  logic [CHN-1:0][DWC-1:0]     m_dat;
  logic                        m_vld;
  logic                        m_rdy = 1'b0;
  logic                        unf;

  always #5 clk = ~clk;

  pwm_dither #(.DWC(DWC), .DWF(DWF), .CHN(CHN), .DWR(DWR)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .ena   (ena),
    .rpt   (rpt),
    .rng   (rng),
    .s_dat (s_dat),
    .s_vld (s_vld),
    .s_rdy (s_rdy),
    .m_dat (m_dat),
    .m_vld (m_vld),
    .m_rdy (m_rdy),
    .unf   (unf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the fraction is tracked as a running total since the
  // last clear; each period's carry is the change in its integer part.
  bit     md_busy;
  int     md_cnt;
  bit     md_unf;
  longint md_sum [CHN];
  int     md_hi  [CHN];
  int     md_hf  [CHN];
  int     md_out [CHN];

  task automatic md_clear();
    md_busy = 1'b0;
    md_cnt  = 0;
    md_unf  = 1'b0;
    for (int c = 0; c < CHN; c++) begin
      md_sum[c] = 0;
      md_hi[c]  = 0;
      md_hf[c]  = 0;
      md_out[c] = 0;
    end
  endtask

  task automatic md_step(input int c);
    longint s1;
    int     v;
    s1        = md_sum[c] + longint'(md_hf[c]);
    v         = md_hi[c] + int'((s1 >> DWF) - (md_sum[c] >> DWF));
    md_sum[c] = s1;
    md_out[c] = (v > int'(rng)) ? int'(rng) : v;
  endtask

  task automatic md_step_all();
    for (int c = 0; c < CHN; c++) md_step(c);
  endtask

  task automatic md_load();
    for (int c = 0; c < CHN; c++) begin
      md_hi[c] = int'(s_dat[c][DWC+DWF-1:DWF]);
      md_hf[c] = int'(s_dat[c][DWF-1:0]);
      md_step(c);
    end
  endtask

  // One clock: check s_rdy mid-cycle, advance the model, check registered outputs.
  task automatic cyc();
    bit er;
    @(negedge clk);
    if (!ena)          er = 1'b0;
    else if (!md_busy) er = 1'b1;
    else               er = m_rdy && (md_cnt >= int'(rpt)) && s_vld;
    chk("s_rdy", 32'(s_rdy), 32'(er));
    md_unf = 1'b0;
    if (!ena) begin
      md_clear();
    end else if (!md_busy) begin
      if (s_vld) begin
        md_load();
        md_cnt  = 0;
        md_busy = 1'b1;
      end else if (HOLD && m_rdy) begin
        md_step_all();
      end
    end else if (m_rdy) begin
      if (md_cnt < int'(rpt)) begin
        md_step_all();
        md_cnt++;
      end else if (s_vld) begin
        md_load();
        md_cnt = 0;
      end else begin
        md_busy = 1'b0;
        md_cnt  = 0;
        md_unf  = 1'b1;
        if (HOLD) md_step_all();
        else for (int c = 0; c < CHN; c++) md_out[c] = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("m_vld", 32'(m_vld), 32'(md_busy));
    chk("unf", 32'(unf), 32'(md_unf));
    for (int c = 0; c < CHN; c++) chk($sformatf("m_dat%0d", c), 32'(m_dat[c]), md_out[c]);
  endtask

  task automatic period(input int idle);
    m_rdy = 1'b0;
    repeat (idle) cyc();
    m_rdy = 1'b1;
    cyc();
    m_rdy = 1'b0;
  endtask

  task automatic flush();
    ena = 1'b0;
    cyc();
    ena = 1'b1;
  endtask

  initial begin
    md_clear();
    #1 rstn = 1'b0;
    #2;
    chk("rst_m_vld", 32'(m_vld), 0);
    chk("rst_unf", 32'(unf), 0);
    chk("rst_m_dat0", 32'(m_dat[0]), 0);
    chk("rst_s_rdy_off", 32'(s_rdy), 0);
    ena = 1'b1;
    #1 chk("rst_s_rdy_on", 32'(s_rdy), 1);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // Dither across four periods.
    rng = 8'd200; rpt = 8'd3;
    s_dat[0] = 16'h0A40; s_dat[1] = 16'h02C0;
    s_vld = 1'b1; cyc(); s_vld = 1'b0;
    chk("dith_a0", 32'(m_dat[0]), 10); chk("dith_a1", 32'(m_dat[1]), 2);
    period(3);
    chk("dith_b0", 32'(m_dat[0]), 10); chk("dith_b1", 32'(m_dat[1]), 3);
    period(3);
    chk("dith_c0", 32'(m_dat[0]), 10); chk("dith_c1", 32'(m_dat[1]), 3);
    period(3);
    chk("dith_d0", 32'(m_dat[0]), 11); chk("dith_d1", 32'(m_dat[1]), 3);
    period(3);
    chk("dith_unf", 32'(unf), 1);
    if (!HOLD) chk("dith_zero", 32'(m_dat[0]), 0);
    cyc();
    period(2);
    period(2);

    // Back-to-back samples with rpt=0.
    flush();
    rpt = 8'd0; rng = 8'd255;
    s_dat[0] = 16'h0580; s_dat[1] = 16'h0580;
    s_vld = 1'b1; cyc();
    chk("b2b_a", 32'(m_dat[0]), 5);
    m_rdy = 1'b1; cyc();
    chk("b2b_b", 32'(m_dat[0]), 6);
    cyc();
    chk("b2b_c", 32'(m_dat[1]), 5);
    s_vld = 1'b0; cyc(); m_rdy = 1'b0;
    cyc();

    // Saturation, including rng=0.
    flush();
    rng = 8'd100; rpt = 8'd1;
    s_dat[0] = 16'hFFFF; s_dat[1] = 16'h6480;
    s_vld = 1'b1; cyc(); s_vld = 1'b0;
    chk("sat_a0", 32'(m_dat[0]), 100); chk("sat_a1", 32'(m_dat[1]), 100);
    period(2);
    chk("sat_b0", 32'(m_dat[0]), 100); chk("sat_b1", 32'(m_dat[1]), 100);
    rng = 8'd0; s_vld = 1'b1; period(2); s_vld = 1'b0;
    chk("rng0_0", 32'(m_dat[0]), 0); chk("rng0_1", 32'(m_dat[1]), 0);

    // Enable drop mid-sample, then the first sample reproduces the int part.
    ena = 1'b0; cyc();
    chk("ena_m_vld", 32'(m_vld), 0); chk("ena_m_dat", 32'(m_dat[1]), 0);
    ena = 1'b1; rng = 8'd255;
    s_dat[0] = 16'h0A40; s_dat[1] = 16'h0580;
    s_vld = 1'b1; cyc(); s_vld = 1'b0;
    chk("reena0", 32'(m_dat[0]), 10); chk("reena1", 32'(m_dat[1]), 5);

    // Asynchronous reset in the middle of a cycle.
    #2 rstn = 1'b0;
    #1;
    chk("arst_m_vld", 32'(m_vld), 0);
    chk("arst_m_dat0", 32'(m_dat[0]), 0);
    chk("arst_m_dat1", 32'(m_dat[1]), 0);
    md_clear();
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // rpt lowered below the current count ends the sample at the next boundary.
    rpt = 8'd5;
    s_dat[0] = 16'h0340; s_vld = 1'b1; cyc(); s_vld = 1'b0;
    period(1); period(1);
    rpt = 8'd1;
    period(1);
    chk("rpt_live_unf", 32'(unf), 1);
    cyc();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      ena   = ($urandom_range(0, 63) != 0);
      s_vld = 1'($urandom_range(0, 1));
      m_rdy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) rpt = DWR'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0)
        rng = ($urandom_range(0, 1) != 0) ? 8'd255 : DWC'($urandom_range(0, 255));
      for (int c = 0; c < CHN; c++) s_dat[c] = 16'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
